// File: rtl/down_rx.sv
// Purpose: downlink serial frame receiver, 4x oversampled, short/long frames into a 20-bit shift register.
// Latency: rxd fall -> START 3 clk; first sample 2*DIV clk later; over/frame_err 1 clk after the deciding sample clk.
// Backpressure: none; the serial line cannot be stalled, so the downstream decoder must keep up with each pulse.
//
// Ports:
//   clk, rstn         single clock, asynchronous active-low reset
//   rxd               asynchronous serial input, idles high
//   tsr[19:0]         receive shift register, MSB-first, stop bit never shifted in
//   no_bits_rcvd[4:0] bits sampled in the current frame (start and stop included)
//   clk_div[1:0]      quarter-bit phase
//   clk1x_en          one-clk pulse per bit sample
//   over              one-clk pulse: valid short frame complete
//   frame_err         one-clk pulse: frame aborted (bad header or bad stop bit)
module down_rx #(
  parameter int DIV = 13
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  output logic [19:0] tsr,
  output logic [4:0]  no_bits_rcvd,
  output logic [1:0]  clk_div,
  output logic        clk1x_en,
  output logic        over,
  output logic        frame_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] QMAX = 16'(DIV - 1);

  logic [1:0]  state;
  logic        rxd_m;
  logic        rxd_s;
  logic        rxd_d;
  logic        fall_q;
  logic        armed;
  logic [15:0] qcnt;
  logic        is_long;
  logic        stop_val;

  logic tick;
  logic sample;
  logic stop_pos;
  logic post;

  assign tick   = (qcnt == QMAX);
  // Mid-bit: the tick that moves clk_div from 1 to 2.
  assign sample = tick && (clk_div == 2'd1) && ((state == S_START) || (state == S_DATA));
  // The sample that lands on the stop bit: 6th for short frames, 22nd for long.
  assign stop_pos = is_long ? (no_bits_rcvd == 5'd21) : (no_bits_rcvd == 5'd5);
  // Cycle right after a DATA sample; decisions use the freshly updated tsr/count.
  // A tick cannot fall here because qcnt was just wrapped to 0.
  assign post   = clk1x_en && (state == S_DATA);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rxd_m        <= 1'b1;
      rxd_s        <= 1'b1;
      rxd_d        <= 1'b1;
      fall_q       <= 1'b0;
      armed        <= 1'b1;
      qcnt         <= '0;
      is_long      <= 1'b0;
      stop_val     <= 1'b0;
      tsr          <= '0;
      no_bits_rcvd <= '0;
      clk_div      <= '0;
      clk1x_en     <= 1'b0;
      over         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      rxd_d     <= rxd_s;
      fall_q    <= rxd_d & ~rxd_s;
      clk1x_en  <= 1'b0;
      over      <= 1'b0;
      frame_err <= 1'b0;

      // Re-arm edge detection only once the line has been seen high.
      if (rxd_s) begin
        armed <= 1'b1;
      end

      // Quarter-bit timebase runs only while a frame is in progress.
      if (state != S_IDLE) begin
        qcnt <= tick ? 16'd0 : qcnt + 16'd1;
        if (tick) begin
          clk_div <= clk_div + 2'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (fall_q && armed) begin
            state        <= S_START;
            tsr          <= '0;
            qcnt         <= '0;
            clk_div      <= '0;
            no_bits_rcvd <= '0;
            is_long      <= 1'b0;
          end
        end

        S_START: begin
          if (sample) begin
            if (!rxd_s) begin
              state        <= S_DATA;
              no_bits_rcvd <= 5'd1;
              clk1x_en     <= 1'b1;
            end else begin
              // Glitch: drop back silently.
              state        <= S_IDLE;
              qcnt         <= '0;
              clk_div      <= '0;
              no_bits_rcvd <= '0;
            end
          end
        end

        S_DATA: begin
          if (sample) begin
            clk1x_en     <= 1'b1;
            no_bits_rcvd <= no_bits_rcvd + 5'd1;
            if (stop_pos) begin
              stop_val <= rxd_s;
            end else begin
              tsr <= {tsr[18:0], rxd_s};
            end
          end else if (post) begin
            if (no_bits_rcvd == 5'd5) begin
              case (tsr[3:0])
                4'b1000, 4'b1100:          is_long <= 1'b0;
                4'b1001, 4'b1010, 4'b1011: is_long <= 1'b1;
                default: begin
                  frame_err    <= 1'b1;
                  armed        <= 1'b0;
                  state        <= S_IDLE;
                  qcnt         <= '0;
                  clk_div      <= '0;
                  no_bits_rcvd <= '0;
                end
              endcase
            end else if ((no_bits_rcvd == 5'd6) && !is_long) begin
              over         <= stop_val;
              frame_err    <= ~stop_val;
              armed        <= stop_val;
              state        <= S_IDLE;
              qcnt         <= '0;
              clk_div      <= '0;
              no_bits_rcvd <= '0;
            end else if ((no_bits_rcvd == 5'd22) && !stop_val) begin
              frame_err    <= 1'b1;
              armed        <= 1'b0;
              state        <= S_IDLE;
              qcnt         <= '0;
              clk_div      <= '0;
              no_bits_rcvd <= '0;
            end
          end else if (tick && (no_bits_rcvd == 5'd22)) begin
            // Same edge moves clk_div 2->3, so {22,3} appears only in DONE.
            state <= S_DONE;
          end
        end

        default: begin
          // S_DONE: hold {22,3} for exactly this one clk.
          state        <= S_IDLE;
          qcnt         <= '0;
          clk_div      <= '0;
          no_bits_rcvd <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_rx.sv
module tb_down_rx;

  localparam int DIV = 4;
  localparam int BIT = 4 * DIV;

  localparam int EV_OVER = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    logic [19:0] tsr;
  } ev_t;

  logic        clk;
  logic        rstn;
  logic        rxd;
  logic [19:0] tsr;
  logic [4:0]  no_bits_rcvd;
  logic [1:0]  clk_div;
  logic        clk1x_en;
  logic        over;
  logic        frame_err;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  last_x1 = -100;
  int  x1_cnt = 0;
  int  base;

  down_rx #(.DIV(DIV)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rxd          (rxd),
    .tsr          (tsr),
    .no_bits_rcvd (no_bits_rcvd),
    .clk_div      (clk_div),
    .clk1x_en     (clk1x_en),
    .over         (over),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [19:0] t);
    ev_t e;
    e.kind = kind;
    e.tsr  = t;
    exp_q.push_back(e);
  endtask

  // Monitor: pop the scoreboard whenever the DUT reports an event.
  task automatic see(input int kind, input logic [19:0] t);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected event: got kind %0d tsr 0x%05h, expected none", kind, t);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind != EV_ERR && e.tsr !== t)) begin
        miscompares++;
        $display("FAIL event: got kind %0d tsr 0x%05h expected kind %0d tsr 0x%05h",
                 kind, t, e.kind, e.tsr);
      end
    end
    if (kind != EV_DONE) begin
      chk("pulse_lat", 32'(cyc - last_x1), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      cyc++;
      if (over) see(EV_OVER, tsr);
      if (frame_err) see(EV_ERR, tsr);
      if (no_bits_rcvd == 5'd22 && clk_div == 2'd3) see(EV_DONE, tsr);
      if (clk1x_en) begin
        x1_cnt++;
        last_x1 = cyc;
      end
    end
  end

  // Each call starts and ends 1 time unit after a rising edge.
  task automatic tx_bit(input logic b);
    rxd = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic tx_word(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tx_bit(v[i]);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    rxd  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tsr", 32'(tsr), 32'h0);
    chk("rst_nb", 32'(no_bits_rcvd), 32'd0);
    chk("rst_div", 32'(clk_div), 32'd0);
    chk("rst_x1", 32'(clk1x_en), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Long frame 1010 / 0x1111
    base = x1_cnt;
    push(EV_DONE, 20'hA1111);
    tx_bit(1'b0); tx_word(16'hA, 4); tx_word(16'h1111, 16); tx_bit(1'b1);
    tx_bit(1'b1); tx_bit(1'b1);
    drain();
    chk("long_x1", 32'(x1_cnt - base), 32'd22);

    // Two short frames back-to-back
    push(EV_OVER, 20'h00008);
    push(EV_OVER, 20'h0000C);
    tx_bit(1'b0); tx_word(16'h8, 4); tx_bit(1'b1);
    tx_bit(1'b0); tx_word(16'hC, 4); tx_bit(1'b1);
    tx_bit(1'b1);
    drain();

    // Start glitch
    base = x1_cnt;
    rxd = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    chk("glitch_x1", 32'(x1_cnt - base), 32'd0);
    chk("glitch_nb", 32'(no_bits_rcvd), 32'd0);
    chk("glitch_div", 32'(clk_div), 32'd0);

    // Bad stop on long frame, line held low, then a valid short frame
    push(EV_ERR, 20'h0);
    tx_bit(1'b0); tx_word(16'hB, 4); tx_word(16'h9C40, 16); tx_bit(1'b0);
    for (int i = 0; i < 10; i++) tx_bit(1'b0);
    tx_bit(1'b1); tx_bit(1'b1);
    drain();
    push(EV_OVER, 20'h00008);
    tx_bit(1'b0); tx_word(16'h8, 4); tx_bit(1'b1); tx_bit(1'b1);
    drain();

    // Invalid header 0111
    push(EV_ERR, 20'h0);
    tx_bit(1'b0); tx_word(16'h7, 4);
    tx_bit(1'b1); tx_bit(1'b1);
    drain();
    chk("badhdr_nb", 32'(no_bits_rcvd), 32'd0);
    chk("badhdr_div", 32'(clk_div), 32'd0);

    // Reset in the middle of a long frame (after the 12th sample)
    tx_bit(1'b0); tx_word(16'hA, 4); tx_word(16'h7F, 7);
    chk("pre_rst_nb", 32'(no_bits_rcvd), 32'd12);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_tsr", 32'(tsr), 32'h0);
    chk("mid_rst_nb", 32'(no_bits_rcvd), 32'd0);
    chk("mid_rst_div", 32'(clk_div), 32'd0);
    chk("mid_rst_x1", 32'(clk1x_en), 32'd0);
    chk("mid_rst_over", 32'(over), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push(EV_DONE, 20'h90010);
    tx_bit(1'b0); tx_word(16'h9, 4); tx_word(16'h0010, 16); tx_bit(1'b1);
    tx_bit(1'b1); tx_bit(1'b1);
    drain();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
